// File: rtl/wind_mode_sequencer.sv
// Tick prescaler and mode selector for the wind-pattern light FSM.
// Mode comes from the manual switches or a calm -> R-to-L -> L-to-R rotation and only changes on ticks.
module wind_mode_sequencer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DWELL    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] man_sw,
  input  logic       auto_en,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] mode,
  output logic       mode_change,
  output logic       auto_active
);

  localparam int PC_W = $clog2(TICK_DIV);
  localparam int DW_W = $clog2(DWELL) + 1;
  localparam logic [PC_W-1:0] PC_MAX    = PC_W'(TICK_DIV - 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_RUN  = 2'd1,
    ST_AUTO_HOLD = 2'd2
  } state_t;

  logic [1:0]      man_sw_meta_r, s_man_sw_r;
  logic            auto_en_meta_r, s_auto_en_r;
  logic            hold_meta_r, s_hold_r;
  logic [PC_W-1:0] pc_r;
  logic            tick_r;
  state_t          state_r;
  logic [DW_W-1:0] dwell_r;
  logic            first_r;
  logic [1:0]      mode_r;
  logic            mode_change_r;
  logic            auto_active_r;
  logic [1:0]      man_mode_s;

  // The switch code 11 has no pattern of its own and falls back to calm.
  function automatic logic [1:0] man_map(input logic [1:0] sw);
    man_map = (sw == 2'b11) ? 2'b00 : sw;
  endfunction

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      2'b00:   next_mode = 2'b01;
      2'b01:   next_mode = 2'b10;
      default: next_mode = 2'b00;
    endcase
  endfunction

  assign man_mode_s = man_map(s_man_sw_r);

  // Two-flop synchronizers for the board switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      man_sw_meta_r  <= 2'b00;
      s_man_sw_r     <= 2'b00;
      auto_en_meta_r <= 1'b0;
      s_auto_en_r    <= 1'b0;
      hold_meta_r    <= 1'b0;
      s_hold_r       <= 1'b0;
    end else begin
      man_sw_meta_r  <= man_sw;
      s_man_sw_r     <= man_sw_meta_r;
      auto_en_meta_r <= auto_en;
      s_auto_en_r    <= auto_en_meta_r;
      hold_meta_r    <= hold;
      s_hold_r       <= hold_meta_r;
    end
  end

  // Prescaler producing the single-cycle step enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r   <= {PC_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      tick_r <= (pc_r == PC_MAX);
      pc_r   <= (pc_r == PC_MAX) ? {PC_W{1'b0}} : pc_r + PC_W'(1);
    end
  end

  // Mode FSM; leaving or entering auto suppresses that cycle's tick update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_MANUAL;
      dwell_r       <= {DW_W{1'b0}};
      first_r       <= 1'b0;
      mode_r        <= 2'b00;
      mode_change_r <= 1'b0;
      auto_active_r <= 1'b0;
    end else begin
      mode_change_r <= 1'b0;
      case (state_r)
        ST_MANUAL: begin
          if (s_auto_en_r) begin
            state_r       <= ST_AUTO_RUN;
            auto_active_r <= 1'b1;
            dwell_r       <= {DW_W{1'b0}};
            first_r       <= 1'b1;
          end else if (tick_r) begin
            mode_r        <= man_mode_s;
            mode_change_r <= (man_mode_s != mode_r);
          end
        end
        ST_AUTO_RUN, ST_AUTO_HOLD: begin
          if (!s_auto_en_r) begin
            state_r       <= ST_MANUAL;
            auto_active_r <= 1'b0;
          end else begin
            state_r <= s_hold_r ? ST_AUTO_HOLD : ST_AUTO_RUN;
            // A hold landing on a tick cycle still lets this tick advance.
            if (tick_r && (state_r == ST_AUTO_RUN)) begin
              if (first_r) begin
                first_r       <= 1'b0;
                dwell_r       <= {DW_W{1'b0}};
                mode_r        <= 2'b00;
                mode_change_r <= (mode_r != 2'b00);
              end else if (dwell_r == DWELL_MAX) begin
                dwell_r       <= {DW_W{1'b0}};
                mode_r        <= next_mode(mode_r);
                mode_change_r <= 1'b1;
              end else begin
                dwell_r <= dwell_r + DW_W'(1);
              end
            end
          end
        end
        default: begin
          state_r       <= ST_MANUAL;
          auto_active_r <= 1'b0;
          first_r       <= 1'b0;
        end
      endcase
    end
  end

  assign tick        = tick_r;
  assign mode        = mode_r;
  assign mode_change = mode_change_r;
  assign auto_active = auto_active_r;

endmodule
